// File: rtl/prog_ctr_pkg.sv
// Shared types and default parameters for the program counter block.
package prog_ctr_pkg;

   localparam int unsigned DEF_A          = 10;
   localparam int unsigned DEF_START_ADDR = 0;

   typedef enum logic [1:0] {IDLE, LOAD, LAUNCH, RUN} pc_state_t;

endpackage

// File: rtl/prog_ctr_if.sv
// Control and address bundle between the core sequencer (master) and the program counter (slave).
interface prog_ctr_if
   import prog_ctr_pkg::*;
#(
   parameter int unsigned A = DEF_A
);
   logic         Start;
   logic         BranchAbsEn;
   logic         BranchRelEn;
   logic         ALU_flag;
   logic [A-1:0] Target;
   logic [A-1:0] ProgCtr;

   modport master (
      output Start, BranchAbsEn, BranchRelEn, ALU_flag, Target,
      input  ProgCtr
   );

   modport slave (
      input  Start, BranchAbsEn, BranchRelEn, ALU_flag, Target,
      output ProgCtr
   );
endinterface

// File: rtl/prog_ctr_next.sv
// Combinational next-PC selection: absolute jump, flag-qualified relative jump, or +1.
module prog_ctr_next
   import prog_ctr_pkg::*;
#(
   parameter int unsigned A = DEF_A
) (
   input  logic [A-1:0] pc,
   input  logic [A-1:0] target,
   input  logic         branchAbsEn,
   input  logic         branchRelEn,
   input  logic         aluFlag,
   output logic [A-1:0] nextPc
);

   // All sums truncate to A bits, so a two's-complement target steps backwards.
   always_comb begin
      nextPc = pc + A'(1);
      if (branchAbsEn) begin
         nextPc = target;
      end else if (branchRelEn && aluFlag) begin
         nextPc = pc + target;
      end
   end

endmodule

// File: rtl/prog_ctr.sv
// Program counter: launch sequencing FSM plus the PC register feeding instruction memory.
module prog_ctr
   import prog_ctr_pkg::*;
#(
   parameter int unsigned A          = DEF_A,
   parameter logic [A-1:0] START_ADDR = A'(DEF_START_ADDR)
) (
   input  logic          Clk,
   input  logic          Reset,
   prog_ctr_if.slave     bus
);

   pc_state_t    stateQ;
   logic [A-1:0] pcQ;
   logic [A-1:0] nextPc;

   prog_ctr_next #(
      .A (A)
   ) uNext (
      .pc          (pcQ),
      .target      (bus.Target),
      .branchAbsEn (bus.BranchAbsEn),
      .branchRelEn (bus.BranchRelEn),
      .aluFlag     (bus.ALU_flag),
      .nextPc      (nextPc)
   );

   // Start always wins; LOAD and LAUNCH both pin the PC so the program sees
   // START_ADDR for two edges after Start falls before counting begins.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateQ <= IDLE;
         pcQ    <= '0;
      end else begin
         unique case (stateQ)
            IDLE: begin
               if (bus.Start) stateQ <= LOAD;
            end
            LOAD: begin
               pcQ <= START_ADDR;
               if (!bus.Start) stateQ <= LAUNCH;
            end
            LAUNCH: begin
               pcQ    <= START_ADDR;
               stateQ <= bus.Start ? LOAD : RUN;
            end
            RUN: begin
               if (bus.Start) begin
                  pcQ    <= START_ADDR;
                  stateQ <= LOAD;
               end else begin
                  pcQ <= nextPc;
               end
            end
            default: begin
               stateQ <= IDLE;
               pcQ    <= '0;
            end
         endcase
      end
   end

   assign bus.ProgCtr = pcQ;

endmodule

// File: tb/tb_prog_ctr.sv
// Self-checking bench for prog_ctr: directed scenarios plus randomized run against a reference model.
module tb_prog_ctr;

   localparam int unsigned A  = 10;
   localparam logic [A-1:0] SA = '0;

   logic Clk = 1'b0;
   logic Reset;
   int   checks   = 0;
   int   failures = 0;

   prog_ctr_if #(.A(A)) bus ();

   prog_ctr #(
      .A          (A),
      .START_ADDR (SA)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic abs, input logic rel, input logic flag,
                        input logic [A-1:0] tgt);
      bus.Start       = s;
      bus.BranchAbsEn = abs;
      bus.BranchRelEn = rel;
      bus.ALU_flag    = flag;
      bus.Target      = tgt;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      Reset = 1'b1;
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL reset_hold: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
      Reset = 1'b0;
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL idle_hold: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 10'd55);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL idle_ignores_branch: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
   endtask

   task automatic test_launch();
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL load: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 10'd77);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL load_exit: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL launch: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd1) begin
         failures++;
         $display("FAIL first_inc: ProgCtr=%0d expected=1", bus.ProgCtr);
      end
   endtask

   task automatic test_branches();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 10'd10);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd10) begin
         failures++;
         $display("FAIL abs_branch: ProgCtr=%0d expected=10", bus.ProgCtr);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 10'd5);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd11) begin
         failures++;
         $display("FAIL rel_not_taken: ProgCtr=%0d expected=11", bus.ProgCtr);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 10'd5);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd16) begin
         failures++;
         $display("FAIL rel_taken: ProgCtr=%0d expected=16", bus.ProgCtr);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h3FF);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd15) begin
         failures++;
         $display("FAIL rel_backward: ProgCtr=%0d expected=15", bus.ProgCtr);
      end
   endtask

   task automatic test_priority_wrap();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 10'd100);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd100) begin
         failures++;
         $display("FAIL abs_priority: ProgCtr=%0d expected=100", bus.ProgCtr);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 10'd1023);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL inc_wrap: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h3FE);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd1022) begin
         failures++;
         $display("FAIL rel_wrap: ProgCtr=%0d expected=1022", bus.ProgCtr);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL async_reset: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
      Reset = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL post_reset_idle: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
   endtask

   task automatic test_restart();
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      tick();
      bus.Start = 1'b0;
      repeat (5) tick();
      checks++;
      if (bus.ProgCtr !== 10'd3) begin
         failures++;
         $display("FAIL run_count: ProgCtr=%0d expected=3", bus.ProgCtr);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 10'd200);
      tick();
      checks++;
      if (bus.ProgCtr !== 10'd0) begin
         failures++;
         $display("FAIL restart_beats_branch: ProgCtr=%0d expected=0", bus.ProgCtr);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      repeat (3) tick();
      checks++;
      if (bus.ProgCtr !== 10'd1) begin
         failures++;
         $display("FAIL relaunch: ProgCtr=%0d expected=1", bus.ProgCtr);
      end
   endtask

   // Model: "active" once Start has been seen since reset; "settle" counts the
   // edges still pinned to the start address after Start drops.
   task automatic test_random();
      logic [A-1:0] mPc;
      bit           active;
      int           settle;
      logic         s, abs, rel, flag;
      logic [A-1:0] tgt;
      Reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
      Reset  = 1'b0;
      mPc    = '0;
      active = 1'b0;
      settle = 0;
      for (int i = 0; i < 800; i++) begin
         s    = ($urandom_range(0, 11) == 0);
         abs  = ($urandom_range(0, 5) == 0);
         rel  = ($urandom_range(0, 2) == 0);
         flag = $urandom_range(0, 1) == 1;
         tgt  = ($urandom_range(0, 7) == 0) ? 10'h3FF : A'($urandom);
         drive(s, abs, rel, flag, tgt);
         if (s) begin
            if (active) mPc = SA;
            active = 1'b1;
            settle = 2;
         end else if (active) begin
            if (settle > 0) begin
               mPc = SA;
               settle--;
            end else if (abs) begin
               mPc = tgt;
            end else if (rel && flag) begin
               mPc = A'(int'(mPc) + int'(tgt));
            end else begin
               mPc = A'(int'(mPc) + 1);
            end
         end
         tick();
         checks++;
         if (bus.ProgCtr !== mPc) begin
            failures++;
            $display("FAIL random[%0d]: ProgCtr=%0d expected=%0d", i, bus.ProgCtr, mPc);
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      test_reset();
      test_launch();
      test_branches();
      test_priority_wrap();
      test_async_reset();
      test_restart();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
